// File: rtl/result_reader.sv
// result_reader: mirror of the CPU result register file.
// Registered random read port plus a valid/ready dump engine.
module result_reader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              eo,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] in,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              beat_acc;

   assign beat_acc = out_valid_q & out_ready;

   // Mirror of the snooped result bus; reset wipes every entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (eo) begin
         mem_q[addr] <= in;
      end
   end

   // Random read, old data wins against a same-cycle write
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   // Dump FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Dump FSM next state; a start outside IDLE is dropped
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = SEND;
         end
         SEND: begin
            if (beat_acc) begin
               state_d = (ptr_q == LAST) ? DONE : LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Dump FSM outputs; the beat is captured once in LOAD and then frozen
   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         IDLE: begin
            if (dump_start) begin
               ptr_d = '0;
            end
         end
         LOAD: begin
            out_addr_d  = ptr_q;
            out_data_d  = mem_q[ptr_q];
            out_valid_d = 1'b1;
         end
         SEND: begin
            if (beat_acc) begin
               out_valid_d = 1'b0;
               if (ptr_q != LAST) begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         DONE: begin
            out_valid_d = 1'b0;
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Registered dump datapath and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign dump_busy = busy_q;
   assign dump_done = done_q;

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: scoreboard bench for result_reader.
// Reference model of the mirror and dump timing, monitor checks beats.
module tb_result_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       eo;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       dump_start;
   logic       dump_busy;
   logic       dump_done;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_addr;
   logic [7:0] out_data;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } beat_t;

   beat_t sbq[$];

   result_reader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .eo         (eo),
      .addr       (addr),
      .in         (wdata),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .dump_start (dump_start),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: mirror contents, read data, and dump progress
   // expressed as "which entry gets sampled next" rather than states.
   logic [7:0] m_mem[16];
   logic [7:0] m_rd = '0;
   bit         m_busy = 0;
   bit         m_done = 0;
   bit         m_valid = 0;
   bit         m_loadp = 0;
   bit         m_nd;
   int         m_k = 0;
   bit         armed = 0;

   always @(negedge clk) begin
      if (armed) begin
         check("rd_data", rd_data, m_rd);
         check("dump_busy", dump_busy, m_busy);
         check("dump_done", dump_done, m_done);
         check("out_valid", out_valid, m_valid);
      end
      if (rst) begin
         for (int i = 0; i < 16; i++) m_mem[i] = '0;
         m_rd = '0;
         m_busy = 0;
         m_done = 0;
         m_valid = 0;
         m_loadp = 0;
         m_k = 0;
         sbq.delete();
         armed = 1;
      end else if (armed) begin
         m_nd = 0;
         if (m_done) begin
            m_busy = 0;
         end else if (!m_busy) begin
            if (dump_start) begin
               m_busy = 1;
               m_loadp = 1;
               m_k = 0;
            end
         end else if (m_loadp) begin
            sbq.push_back('{4'(m_k), m_mem[m_k]});
            m_loadp = 0;
            m_valid = 1;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
            if (m_k == 15) begin
               m_nd = 1;
            end else begin
               m_k++;
               m_loadp = 1;
            end
         end
         m_done = m_nd;
         m_rd = m_mem[rd_addr];
         if (eo) m_mem[addr] = wdata;
      end
   end

   // Monitor: pops expected beats on handshakes, checks held beats
   bit         prev_hold = 0;
   logic [3:0] pa;
   logic [7:0] pd;
   beat_t      eb;

   always @(negedge clk) begin
      if (armed && !rst) begin
         if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_addr", out_addr, pa);
            check("hold_data", out_data, pd);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("beat_extra", out_valid, 0);
            end else begin
               eb = sbq.pop_front();
               check("beat_addr", out_addr, eb.a);
               check("beat_data", out_data, eb.d);
            end
         end
      end
      prev_hold = armed && !rst && out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep_read();
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         step();
      end
      step();
   endtask

   // lat counts cycles from the start cycle to the dump_done cycle
   task automatic run_dump(input int mode, output int lat);
      int hold = 0;
      bit w2 = 0;
      bit w12 = 0;
      bit s2 = 0;
      bit quit = 0;
      dump_start = 1;
      out_ready = 1;
      step();
      dump_start = 0;
      lat = 1;
      while (!dump_done && !quit && lat < 300) begin
         eo = 0;
         dump_start = 0;
         out_ready = 1;
         case (mode)
            1: begin
               if (out_valid && out_addr == 4'd7 && hold < 5) begin
                  out_ready = 0;
                  hold++;
               end
            end
            2: begin
               if (out_valid && out_addr == 4'd3 && !w2) begin
                  eo = 1; addr = 4'd2; wdata = 8'h5A; w2 = 1;
               end
               if (out_valid && out_addr == 4'd5 && !w12) begin
                  eo = 1; addr = 4'd12; wdata = 8'hC3; w12 = 1;
               end
               if (out_valid && out_addr == 4'd8 && !s2) begin
                  dump_start = 1; s2 = 1;
               end
            end
            3: begin
               if (out_valid && out_addr == 4'd9) begin
                  rst = 1;
                  quit = 1;
               end
            end
            default: ;
         endcase
         step();
         lat++;
      end
      if (quit) begin
         rst = 0;
      end else if (!dump_done) begin
         check("dump_timeout", dump_done, 1);
      end
      eo = 0;
      dump_start = 0;
      out_ready = 1;
   endtask

   int lat;
   int guard;

   initial begin
      rst = 1;
      eo = 0;
      addr = '0;
      wdata = '0;
      rd_addr = '0;
      dump_start = 0;
      out_ready = 1;
      step();
      step();
      rst = 0;
      sweep_read();

      eo = 1; addr = 4'd3; wdata = 8'hA5; rd_addr = 4'd3;
      step();
      eo = 0;
      step();
      step();

      for (int i = 0; i < 16; i++) begin
         eo = 1; addr = 4'(i); wdata = 8'(i * 8'h11);
         step();
      end
      eo = 0;
      step();

      run_dump(0, lat);
      check("lat_full", lat, 33);
      step();
      step();

      run_dump(1, lat);
      check("lat_backpressure", lat, 38);
      step();
      step();

      run_dump(2, lat);
      check("lat_concurrent", lat, 33);
      for (int i = 0; i < 4; i++) step();

      run_dump(3, lat);
      step();
      sweep_read();
      run_dump(0, lat);
      check("lat_after_rst", lat, 33);
      step();
      step();

      for (int c = 0; c < 3000; c++) begin
         eo = 1'($urandom_range(0, 1));
         addr = 4'($urandom_range(0, 15));
         wdata = 8'($urandom_range(0, 255));
         rd_addr = 4'($urandom_range(0, 15));
         dump_start = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 0;
      eo = 0;
      dump_start = 0;
      out_ready = 1;
      guard = 0;
      while (dump_busy && guard < 100) begin
         step();
         guard++;
      end
      check("final_idle", dump_busy, 0);
      step();
      check("sb_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
